// File: rtl/serial_byte_matcher_pkg.sv
// Shared constants and state type for the serial byte matcher.
// The byte width and last-bit index are tied together and must change together.
package serial_byte_matcher_pkg;

  localparam int         BYTE_W   = 8;
  localparam logic [2:0] LAST_BIT = 3'd7;

  typedef enum logic {
    ST_SHIFT = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/serial_byte_matcher_equ_8bit.sv
// 8-bit equality comparator that checks an assembled byte against the pattern.
module equ_8bit (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic       o_eq
);

  assign o_eq = (i_a == i_b);

endmodule

// File: rtl/serial_byte_matcher.sv
// MSB-first serial-to-byte deserialiser with pattern match, valid/ready output
// and a saturating count of delivered matching bytes.
module serial_byte_matcher
  import serial_byte_matcher_pkg::*;
#(
  parameter logic [7:0] RESET_PAT = 8'hA5,
  parameter int         COUNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sync_clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_bit,
  input  logic               pat_load,
  input  logic [7:0]         pat_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_byte,
  output logic               out_match,
  output logic [COUNT_W-1:0] match_count
);

  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_e               r_state;
  state_e               w_next_state;
  logic [2:0]           r_bit_cnt;
  logic [6:0]           r_sr;
  logic [7:0]           r_pat;
  logic [7:0]           r_out_byte;
  logic                 r_out_match;
  logic [COUNT_W-1:0]   r_count;

  logic [BYTE_W-1:0]    w_byte;
  logic                 w_eq;
  logic                 w_in_ready;
  logic                 w_out_valid;
  logic                 w_bit_acc;
  logic                 w_byte_done;
  logic                 w_out_acc;

  // The byte completing this cycle is the shift register plus the incoming bit.
  assign w_byte      = {r_sr, in_bit};
  assign w_bit_acc   = in_valid & w_in_ready;
  assign w_byte_done = w_bit_acc & (r_bit_cnt == LAST_BIT);
  assign w_out_acc   = w_out_valid & out_ready;

  equ_8bit u_equ (
    .i_a  (w_byte),
    .i_b  (r_pat),
    .o_eq (w_eq)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_SHIFT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; a byte may complete in the same cycle HOLD is consumed
  always_comb begin
    w_next_state = r_state;
    if (sync_clr) begin
      w_next_state = ST_SHIFT;
    end else begin
      case (r_state)
        ST_SHIFT: w_next_state = w_byte_done ? ST_HOLD : ST_SHIFT;
        ST_HOLD: begin
          if (out_ready) begin
            w_next_state = w_byte_done ? ST_HOLD : ST_SHIFT;
          end else begin
            w_next_state = ST_HOLD;
          end
        end
        default: w_next_state = ST_SHIFT;
      endcase
    end
  end

  // FSM outputs: handshake flags derived from state, out_ready and sync_clr
  always_comb begin
    w_out_valid = 1'b0;
    w_in_ready  = 1'b0;
    case (r_state)
      ST_SHIFT: begin
        w_out_valid = 1'b0;
        w_in_ready  = ~sync_clr;
      end
      ST_HOLD: begin
        w_out_valid = 1'b1;
        w_in_ready  = ~sync_clr & out_ready;
      end
      default: begin
        w_out_valid = 1'b0;
        w_in_ready  = 1'b0;
      end
    endcase
  end

  // Shift register, bit counter and captured output byte/match flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt   <= 3'd0;
      r_sr        <= 7'd0;
      r_out_byte  <= 8'd0;
      r_out_match <= 1'b0;
    end else if (sync_clr) begin
      r_bit_cnt   <= 3'd0;
      r_sr        <= 7'd0;
      r_out_match <= 1'b0;
    end else if (w_byte_done) begin
      r_bit_cnt   <= 3'd0;
      r_sr        <= 7'd0;
      r_out_byte  <= w_byte;
      r_out_match <= w_eq;
    end else if (w_bit_acc) begin
      r_bit_cnt   <= r_bit_cnt + 3'd1;
      r_sr        <= w_byte[6:0];
    end else begin
      r_bit_cnt   <= r_bit_cnt;
      r_sr        <= r_sr;
    end
  end

  // Pattern register survives sync_clr; a same-cycle compare still sees the old value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat <= RESET_PAT;
    end else if (pat_load) begin
      r_pat <= pat_in;
    end else begin
      r_pat <= r_pat;
    end
  end

  // Saturating count of consumed bytes that matched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {COUNT_W{1'b0}};
    end else if (sync_clr) begin
      r_count <= {COUNT_W{1'b0}};
    end else if (w_out_acc && r_out_match && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = w_out_valid;
  assign out_byte    = r_out_byte;
  assign out_match   = r_out_match;
  assign match_count = r_count;

endmodule

// File: tb/tb_serial_byte_matcher.sv
// Self-checking bench: randomised serial stimulus against a byte-level reference model.
module tb_serial_byte_matcher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sync_clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       pat_load = 1'b0;
  logic [7:0] pat_in = 8'h00;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, out_match;
  logic [7:0] out_byte, match_count;
  logic       in_ready2, out_valid2, out_match2;
  logic [7:0] out_byte2;
  logic [1:0] match_count2;

  int tests = 0;
  int fails = 0;

  // reference model state
  int         m_bits, m_acc, m_total;
  logic       m_hold, m_out_match;
  logic [7:0] m_out_byte, m_pat;
  logic       exp_rdy, obs_rdy, acc_flag;

  serial_byte_matcher dut (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .in_valid(in_valid),
    .in_ready(in_ready), .in_bit(in_bit), .pat_load(pat_load), .pat_in(pat_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_match(out_match), .match_count(match_count)
  );

  serial_byte_matcher #(.RESET_PAT(8'hA5), .COUNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .in_valid(in_valid),
    .in_ready(in_ready2), .in_bit(in_bit), .pat_load(pat_load), .pat_in(pat_in),
    .out_valid(out_valid2), .out_ready(out_ready), .out_byte(out_byte2),
    .out_match(out_match2), .match_count(match_count2)
  );

  always #5 clk = ~clk;

  function automatic int exp8();
    return (m_total > 255) ? 255 : m_total;
  endfunction

  function automatic int exp2();
    return (m_total > 3) ? 3 : m_total;
  endfunction

  task automatic model_reset();
    m_bits = 0; m_acc = 0; m_total = 0; m_hold = 1'b0;
    m_out_match = 1'b0; m_out_byte = 8'h00; m_pat = 8'hA5;
  endtask

  // one clock: drive at negedge, observe in_ready, step model at posedge
  task automatic cycle(input logic iv, input logic ib, input logic ordy,
                       input logic pl, input logic [7:0] pin, input logic clr);
    in_valid = iv; in_bit = ib; out_ready = ordy; pat_load = pl; pat_in = pin; sync_clr = clr;
    exp_rdy  = !clr && (!m_hold || ordy);
    acc_flag = iv && exp_rdy;
    #1;
    obs_rdy = in_ready;
    @(posedge clk);
    if (clr) begin
      m_bits = 0; m_acc = 0; m_hold = 1'b0; m_out_match = 1'b0; m_total = 0;
    end else begin
      if (m_hold && ordy) begin
        m_total = m_total + (m_out_match ? 1 : 0);
        m_hold  = 1'b0;
      end
      if (acc_flag) begin
        m_acc  = ((m_acc * 2) + (ib ? 1 : 0)) % 256;
        m_bits = m_bits + 1;
        if (m_bits == 8) begin
          m_out_byte  = m_acc[7:0];
          m_out_match = (m_acc[7:0] == m_pat);
          m_hold      = 1'b1;
          m_bits      = 0;
        end
      end
    end
    if (pl) m_pat = pin;
    @(negedge clk);
    in_valid = 1'b0; pat_load = 1'b0; sync_clr = 1'b0;
  endtask

  // send one byte MSB first with out_ready=1; optional pattern load on the last bit
  task automatic send_byte(input logic [7:0] b, input logic pl_last, input logic [7:0] pin);
    for (int i = 7; i >= 0; i--) begin
      int budget = 0;
      do begin
        cycle(1'b1, b[i], 1'b1, pl_last && (i == 0), pin, 1'b0);
        budget++;
      end while (!acc_flag && budget < 20);
      if (!acc_flag) begin
        fails++; tests++;
        $display("FAIL send_byte_timeout: bit %0d never accepted", i);
      end
    end
  endtask

  task automatic test_reset();
    send_byte(8'hFF, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    #2;
    tests++; if ({out_valid, out_byte, out_match, match_count} !== 17'd0) begin
      fails++; $display("FAIL reset_outputs: got %0h want 0", {out_valid, out_byte, out_match, match_count});
    end
    @(negedge clk); rst_n = 1'b1; model_reset();
    in_valid = 1'b0; out_ready = 1'b0; #1;
    tests++; if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    send_byte(8'hA5, 1'b0, 8'h00);
    tests++; if ({out_valid, out_byte, out_match} !== {1'b1, 8'hA5, 1'b1}) begin
      fails++; $display("FAIL reset_first_byte: got v=%b b=%h m=%b want v=1 b=a5 m=1", out_valid, out_byte, out_match);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    tests++; if (match_count !== 8'd1) begin
      fails++; $display("FAIL reset_count: got %0d want 1", match_count);
    end
  endtask

  task automatic test_mismatch();
    send_byte(8'h3C, 1'b0, 8'h00);
    tests++; if ({out_valid, out_byte, out_match} !== {1'b1, 8'h3C, 1'b0}) begin
      fails++; $display("FAIL mismatch_byte: got v=%b b=%h m=%b want v=1 b=3c m=0", out_valid, out_byte, out_match);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    tests++; if (match_count !== 8'(exp8())) begin
      fails++; $display("FAIL mismatch_count: got %0d want %0d", match_count, exp8());
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] b1, b2;
    b1 = 8'($urandom); b2 = 8'($urandom);
    send_byte(b1, 1'b0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, b2[7], 1'b0, 1'b0, 8'h00, 1'b0);
      tests++; if (obs_rdy !== 1'b0 || out_byte !== b1 || out_valid !== 1'b1) begin
        fails++; $display("FAIL bp_stall: rdy=%b byte=%h v=%b want rdy=0 byte=%h v=1", obs_rdy, out_byte, out_valid, b1);
      end
    end
    cycle(1'b1, b2[7], 1'b1, 1'b0, 8'h00, 1'b0);
    tests++; if (obs_rdy !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL bp_release: rdy=%b v=%b want rdy=1 v=0", obs_rdy, out_valid);
    end
    for (int i = 6; i >= 0; i--) cycle(1'b1, b2[i], 1'b1, 1'b0, 8'h00, 1'b0);
    tests++; if ({out_valid, out_byte} !== {1'b1, b2}) begin
      fails++; $display("FAIL bp_next_byte: got v=%b b=%h want v=1 b=%h", out_valid, out_byte, b2);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_pattern();
    send_byte(8'h5A, 1'b1, 8'h5A);
    tests++; if ({out_byte, out_match} !== {8'h5A, 1'b0}) begin
      fails++; $display("FAIL pat_old_compare: got b=%h m=%b want b=5a m=0", out_byte, out_match);
    end
    send_byte(8'h5A, 1'b0, 8'h00);
    tests++; if ({out_byte, out_match} !== {8'h5A, 1'b1}) begin
      fails++; $display("FAIL pat_new_compare: got b=%h m=%b want b=5a m=1", out_byte, out_match);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_sync_clr();
    for (int i = 7; i >= 4; i--) cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    tests++; if (out_valid !== 1'b0 || match_count !== 8'd0 || obs_rdy !== 1'b0) begin
      fails++; $display("FAIL clr_midbyte: v=%b cnt=%0d rdy=%b want v=0 cnt=0 rdy=0", out_valid, match_count, obs_rdy);
    end
    send_byte(m_pat, 1'b0, 8'h00);
    tests++; if ({out_valid, out_byte, out_match} !== {1'b1, m_pat, 1'b1}) begin
      fails++; $display("FAIL clr_fresh_byte: got v=%b b=%h m=%b want v=1 b=%h m=1", out_valid, out_byte, out_match, m_pat);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    tests++; if (out_valid !== 1'b0 || match_count !== 8'd0) begin
      fails++; $display("FAIL clr_hold: v=%b cnt=%0d want v=0 cnt=0", out_valid, match_count);
    end
    send_byte(8'hC3, 1'b0, 8'h00);
    tests++; if ({out_byte, out_match} !== {8'hC3, 1'b0}) begin
      fails++; $display("FAIL clr_after_hold: got b=%h m=%b want b=c3 m=0", out_byte, out_match);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_saturation();
    int want [5] = '{1, 2, 3, 3, 3};
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 5; k++) begin
      send_byte(m_pat, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      tests++; if (match_count2 !== 2'(want[k])) begin
        fails++; $display("FAIL sat_count_w2: byte %0d got %0d want %0d", k, match_count2, want[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int n = 0; n < 340; n++) begin
      b = ($urandom_range(9, 0) < 9) ? m_pat : 8'($urandom);
      for (int i = 7; i >= 0; i--) begin
        int budget = 0;
        do begin
          cycle($urandom_range(3, 0) != 0, b[i], $urandom_range(2, 0) != 0, 1'b0, 8'h00, 1'b0);
          budget++;
          tests++; if (obs_rdy !== exp_rdy || out_valid !== m_hold ||
                       match_count !== 8'(exp8()) || match_count2 !== 2'(exp2()) ||
                       (m_hold && (out_byte !== m_out_byte || out_match !== m_out_match))) begin
            fails++;
            $display("FAIL random: rdy=%b/%b v=%b/%b b=%h/%h m=%b/%b cnt=%0d/%0d cnt2=%0d/%0d",
                     obs_rdy, exp_rdy, out_valid, m_hold, out_byte, m_out_byte, out_match, m_out_match,
                     match_count, exp8(), match_count2, exp2());
          end
        end while (!acc_flag && budget < 50);
        if (!acc_flag) begin
          fails++; tests++;
          $display("FAIL random_timeout: bit %0d of byte %0d never accepted", i, n);
        end
      end
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    tests++; if (match_count !== 8'(exp8()) || m_total < 255 || match_count !== 8'd255) begin
      fails++; $display("FAIL random_saturated: got %0d want 255 (model total %0d)", match_count, m_total);
    end
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_mismatch();
    test_backpressure();
    test_pattern();
    test_sync_clr();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
